// File: rtl/load_mem_issue.sv
// Load memory issue stage.
// Takes the oldest load from the load queue head once its address is resolved. It issues a
// tagged 64-bit read on the proc2mem/mem2proc bus and waits for the matching tag. It then
// extracts and sign/zero-extends the requested byte/half/word and holds the result on the CDB
// until it is granted. On grant it pulses lq_retire_o so the load queue pops its head.
//
// Ports:
//   clock_i, reset_i         clock and synchronous active-high reset
//   lq_head_*_i              oldest load: valid, resolved, address, dest tag, size, unsigned
//   flush_i                  pipeline flush; drops the current load
//   proc2mem_command_o/addr  read request (BUS_LOAD, 8-byte aligned address)
//   mem2proc_response_i      accepted-request tag, 0 = rejected
//   mem2proc_data_i/tag_i    returning doubleword and its tag, tag 0 = none
//   cdb_valid/value/prf_idx  result broadcast; cdb_grant_i accepts it
//   lq_retire_o              one-cycle pop of the load queue head
//   busy_o                   stage is not idle
module load_mem_issue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PRF_IDX_LEN = 6,
  parameter int unsigned MEM_TAG_LEN = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   lq_head_valid_i,
  input  logic                   lq_head_resolved_i,
  input  logic [XLEN-1:0]        lq_head_address_i,
  input  logic [PRF_IDX_LEN-1:0] lq_head_prf_idx_i,
  input  logic [1:0]             lq_head_size_i,
  input  logic                   lq_head_unsigned_i,
  input  logic                   flush_i,
  output logic [1:0]             proc2mem_command_o,
  output logic [XLEN-1:0]        proc2mem_addr_o,
  input  logic [MEM_TAG_LEN-1:0] mem2proc_response_i,
  input  logic [63:0]            mem2proc_data_i,
  input  logic [MEM_TAG_LEN-1:0] mem2proc_tag_i,
  output logic                   cdb_valid_o,
  output logic [XLEN-1:0]        cdb_value_o,
  output logic [PRF_IDX_LEN-1:0] cdb_prf_idx_o,
  input  logic                   cdb_grant_i,
  output logic                   lq_retire_o,
  output logic                   busy_o
);

  localparam logic [1:0] BusNone = 2'd0;
  localparam logic [1:0] BusLoad = 2'd1;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [PRF_IDX_LEN-1:0] prf_q, prf_d;
  logic [1:0]             size_q, size_d;
  logic                   unsigned_q, unsigned_d;
  logic [MEM_TAG_LEN-1:0] tag_q, tag_d;
  logic [63:0]            data_q, data_d;

  logic tag_match;
  assign tag_match = (mem2proc_tag_i != '0) && (mem2proc_tag_i == tag_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    prf_d      = prf_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    tag_d      = tag_q;
    data_d     = data_q;
    case (state_q)
      StIdle: begin
        if (!flush_i && lq_head_valid_i && lq_head_resolved_i) begin
          state_d    = StReq;
          addr_d     = lq_head_address_i;
          prf_d      = lq_head_prf_idx_i;
          size_d     = lq_head_size_i;
          unsigned_d = lq_head_unsigned_i;
        end
      end
      StReq: begin
        if (mem2proc_response_i != '0) begin
          tag_d = mem2proc_response_i;
          // An accepted request under flush still owns a tag; drain it so it is not
          // mistaken for the reply of a later load.
          state_d = flush_i ? StDrain : StWait;
        end else if (flush_i) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (tag_match) begin
          if (flush_i) begin
            state_d = StIdle;
          end else begin
            data_d  = mem2proc_data_i;
            state_d = StDone;
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        // Flush beats grant: the result is dropped and the head is not retired.
        if (flush_i || cdb_grant_i) state_d = StIdle;
      end
      StDrain: begin
        if (tag_match) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      prf_q      <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      prf_q      <= prf_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  // Field extraction from the latched doubleword; low address bits inside the field are ignored.
  logic [31:0]     word_f;
  logic [15:0]     half_f;
  logic [7:0]      byte_f;
  logic [XLEN-1:0] ext_value;

  always_comb begin
    word_f = data_q[{addr_q[2], 5'b0} +: 32];
    half_f = data_q[{addr_q[2:1], 4'b0} +: 16];
    byte_f = data_q[{addr_q[2:0], 3'b0} +: 8];
    case (size_q)
      2'd0:    ext_value = unsigned_q ? XLEN'(byte_f) : XLEN'($signed(byte_f));
      2'd1:    ext_value = unsigned_q ? XLEN'(half_f) : XLEN'($signed(half_f));
      default: ext_value = unsigned_q ? XLEN'(word_f) : XLEN'($signed(word_f));
    endcase
  end

  assign proc2mem_command_o = (state_q == StReq) ? BusLoad : BusNone;
  assign proc2mem_addr_o    = (state_q == StReq) ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign cdb_valid_o        = (state_q == StDone);
  assign cdb_value_o        = (state_q == StDone) ? ext_value : '0;
  assign cdb_prf_idx_o      = (state_q == StDone) ? prf_q : '0;
  assign lq_retire_o        = (state_q == StDone) && cdb_grant_i && !flush_i;
  assign busy_o             = (state_q != StIdle);

endmodule

// File: tb/tb_load_mem_issue.sv
module tb_load_mem_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        lq_head_valid, lq_head_resolved, lq_head_unsigned, flush;
  logic [31:0] lq_head_address;
  logic [5:0]  lq_head_prf_idx;
  logic [1:0]  lq_head_size;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        cdb_valid, cdb_grant, lq_retire, busy;
  logic [31:0] cdb_value;
  logic [5:0]  cdb_prf_idx;

  always #5 clk = ~clk;

  load_mem_issue dut (
    .clock_i            (clk),
    .reset_i            (reset),
    .lq_head_valid_i    (lq_head_valid),
    .lq_head_resolved_i (lq_head_resolved),
    .lq_head_address_i  (lq_head_address),
    .lq_head_prf_idx_i  (lq_head_prf_idx),
    .lq_head_size_i     (lq_head_size),
    .lq_head_unsigned_i (lq_head_unsigned),
    .flush_i            (flush),
    .proc2mem_command_o (proc2mem_command),
    .proc2mem_addr_o    (proc2mem_addr),
    .mem2proc_response_i(mem2proc_response),
    .mem2proc_data_i    (mem2proc_data),
    .mem2proc_tag_i     (mem2proc_tag),
    .cdb_valid_o        (cdb_valid),
    .cdb_value_o        (cdb_value),
    .cdb_prf_idx_o      (cdb_prf_idx),
    .cdb_grant_i        (cdb_grant),
    .lq_retire_o        (lq_retire),
    .busy_o             (busy)
  );

  typedef struct packed {
    logic [5:0]  prf;
    logic [31:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a load at the queue head for one edge; the DUT should then be in REQ.
  task automatic issue_load(input logic [31:0] addr, input logic [5:0] prf, input logic [1:0] size,
                            input logic uns, input logic expect_result, input logic [31:0] value);
    lq_head_valid    = 1'b1;
    lq_head_resolved = 1'b1;
    lq_head_address  = addr;
    lq_head_prf_idx  = prf;
    lq_head_size     = size;
    lq_head_unsigned = uns;
    if (expect_result) sb_q.push_back('{prf: prf, value: value});
    tick();
    lq_head_valid = 1'b0;
    check("req_command", proc2mem_command, 2'd1);
    check("req_addr", proc2mem_addr, {addr[31:3], 3'b000});
  endtask

  task automatic respond(input logic [3:0] tag);
    mem2proc_response = tag;
    tick();
    mem2proc_response = '0;
  endtask

  task automatic return_data(input logic [3:0] tag, input logic [63:0] data);
    mem2proc_tag  = tag;
    mem2proc_data = data;
    tick();
    mem2proc_tag  = '0;
    mem2proc_data = '0;
  endtask

  // Waits (bounded) for a CDB result, compares it with the scoreboard head, then grants it.
  task automatic grant_and_check();
    exp_t e;
    int   n = 0;
    while (!cdb_valid && n < 20) begin
      tick();
      n++;
    end
    check("cdb_valid_wait", cdb_valid, 1'b1);
    check("sb_nonempty", sb_q.size() != 0, 1'b1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("cdb_value", cdb_value, e.value);
      check("cdb_prf_idx", cdb_prf_idx, e.prf);
    end
    cdb_grant = 1'b1;
    #1;
    check("retire_on_grant", lq_retire, 1'b1);
    tick();
    cdb_grant = 1'b0;
    #1;
    check("retire_single_pulse", lq_retire, 1'b0);
    check("cdb_valid_after_grant", cdb_valid, 1'b0);
    check("idle_after_grant", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    lq_head_valid = 1'b0; lq_head_resolved = 1'b0; lq_head_address = '0;
    lq_head_prf_idx = '0; lq_head_size = '0; lq_head_unsigned = 1'b0; flush = 1'b0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0; cdb_grant = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst_command", proc2mem_command, 2'd0);
    check("rst_addr", proc2mem_addr, 32'h0);
    check("rst_cdb_valid", cdb_valid, 1'b0);
    check("rst_cdb_value", cdb_value, 32'h0);
    check("rst_retire", lq_retire, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Signed half at 0x1006, tag 3.
    issue_load(32'h1006, 6'd5, 2'd1, 1'b0, 1'b1, 32'hFFFF_8001);
    respond(4'd3);
    check("wait_command", proc2mem_command, 2'd0);
    check("wait_busy", busy, 1'b1);
    return_data(4'd3, 64'h8001_0000_0000_0000);
    grant_and_check();

    // Three rejections then accept with tag 5; a non-matching tag must be ignored.
    issue_load(32'h3008, 6'd9, 2'd2, 1'b0, 1'b1, 32'hCAFE_BABE);
    for (int i = 0; i < 3; i++) begin
      check("reissue_command", proc2mem_command, 2'd1);
      tick();
    end
    check("reissue_command_last", proc2mem_command, 2'd1);
    respond(4'd5);
    check("wait_after_retry", proc2mem_command, 2'd0);
    return_data(4'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrong_tag_ignored", cdb_valid, 1'b0);
    return_data(4'd5, 64'h1234_5678_CAFE_BABE);
    grant_and_check();

    // Byte at 0x2003, unsigned then signed.
    issue_load(32'h2003, 6'd12, 2'd0, 1'b1, 1'b1, 32'h0000_00F0);
    respond(4'd1);
    return_data(4'd1, 64'h0000_0000_F000_0000);
    grant_and_check();
    issue_load(32'h2003, 6'd13, 2'd0, 1'b0, 1'b1, 32'hFFFF_FFF0);
    respond(4'd1);
    return_data(4'd1, 64'h0000_0000_F000_0000);
    grant_and_check();

    // Flush in WAIT with tag 7 outstanding; next head waits until tag 7 drains.
    issue_load(32'h4000, 6'd1, 2'd2, 1'b0, 1'b0, 32'h0);
    respond(4'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    lq_head_valid = 1'b1; lq_head_resolved = 1'b1; lq_head_address = 32'h5004;
    lq_head_prf_idx = 6'd2; lq_head_size = 2'd2; lq_head_unsigned = 1'b0;
    sb_q.push_back('{prf: 6'd2, value: 32'h89AB_CDEF});
    for (int i = 0; i < 3; i++) begin
      check("drain_no_req", proc2mem_command, 2'd0);
      check("drain_busy", busy, 1'b1);
      check("drain_no_cdb", cdb_valid, 1'b0);
      tick();
    end
    mem2proc_tag = 4'd7;
    mem2proc_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem2proc_tag = '0;
    check("drain_done_idle", busy, 1'b0);
    check("drain_stale_cdb", cdb_valid, 1'b0);
    tick();
    lq_head_valid = 1'b0;
    check("post_drain_req", proc2mem_command, 2'd1);
    check("post_drain_addr", proc2mem_addr, 32'h5000);
    respond(4'd4);
    return_data(4'd4, 64'h89AB_CDEF_0000_0000);
    grant_and_check();

    // Flush together with the matching response in WAIT goes straight to IDLE.
    issue_load(32'h7000, 6'd3, 2'd2, 1'b0, 1'b0, 32'h0);
    respond(4'd2);
    mem2proc_tag = 4'd2;
    flush = 1'b1;
    tick();
    mem2proc_tag = '0;
    flush = 1'b0;
    check("flush_resp_idle", busy, 1'b0);
    check("flush_resp_no_cdb", cdb_valid, 1'b0);

    // Grant withheld in DONE; then grant together with flush.
    issue_load(32'h6000, 6'd20, 2'd2, 1'b1, 1'b1, 32'h6666_5555);
    respond(4'd9);
    return_data(4'd9, 64'h7777_8888_6666_5555);
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", cdb_valid, 1'b1);
      check("hold_value", cdb_value, e.value);
      check("hold_prf", cdb_prf_idx, e.prf);
      check("hold_no_retire", lq_retire, 1'b0);
      tick();
    end
    cdb_grant = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_grant_no_retire", lq_retire, 1'b0);
    tick();
    cdb_grant = 1'b0;
    flush = 1'b0;
    check("flush_grant_idle", busy, 1'b0);
    check("flush_grant_no_cdb", cdb_valid, 1'b0);

    // Reset mid-WAIT.
    issue_load(32'h8000, 6'd7, 2'd2, 1'b0, 1'b0, 32'h0);
    respond(4'd6);
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_wait_busy", busy, 1'b0);
    check("reset_wait_cdb", cdb_valid, 1'b0);
    check("reset_wait_retire", lq_retire, 1'b0);
    check("reset_wait_command", proc2mem_command, 2'd0);

    check("sb_empty_at_end", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
